// File: rtl/i2c_config_seq.sv
// Walks a read-only table of {sub, data} register writes and hands each one to a
// downstream I2C writer as a 27-bit frame. Optional macro I2C_CFG_RETRY_EN reissues a NACKed entry.
module i2c_config_seq #(
    parameter int          N_ENTRIES  = 10,
    parameter int          GAP_CYCLES = 200,
    parameter logic [7:0]  DEV_ADDR   = 8'h34
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic        i_wr_done,
    input  logic        i_ack,
    output logic [26:0] o_regdata,
    output logic        o_go,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err,
    output logic [3:0]  o_index
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_FIRE  = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_CHECK = 3'd4;
    localparam logic [2:0] S_GAP   = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;
    localparam logic [2:0] S_ERR   = 3'd7;

    localparam logic [3:0]  LAST_IDX = 4'(N_ENTRIES - 1);
    localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);

    // Default table contents: entry k writes data 0x10+k to sub-address 2k.
    function automatic logic [15:0] table_entry(input logic [3:0] k);
        logic [7:0] sub;
        logic [7:0] data;
        sub  = {3'b000, k, 1'b0};
        data = 8'h10 + {4'h0, k};
        return {sub, data};
    endfunction

    logic [2:0]  r_state;
    logic [26:0] r_regdata;
    logic        r_go;
    logic        r_busy;
    logic        r_done;
    logic        r_err;
    logic [3:0]  r_index;
    logic        r_ack;
    logic [15:0] r_gap_cnt;
`ifdef I2C_CFG_RETRY_EN
    logic [1:0]  r_retry;
`endif

    logic [15:0] w_entry;

    assign w_entry = table_entry(r_index);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= S_IDLE;
            r_regdata <= '0;
            r_go      <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_index   <= '0;
            r_ack     <= 1'b0;
            r_gap_cnt <= '0;
`ifdef I2C_CFG_RETRY_EN
            r_retry   <= '0;
`endif
        end else begin
            // NOTE: GO defaults low every cycle so it can only ever be a single-cycle pulse.
            r_go <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (i_start) begin
                        r_state <= S_LOAD;
                        r_index <= '0;
                        r_done  <= 1'b0;
                        r_err   <= 1'b0;
                        r_busy  <= 1'b1;
`ifdef I2C_CFG_RETRY_EN
                        r_retry <= '0;
`endif
                    end
                end
                S_LOAD: begin
                    r_regdata <= {DEV_ADDR, 1'b1, w_entry[15:8], 1'b1, w_entry[7:0], 1'b1};
                    r_go      <= 1'b1;
                    r_state   <= S_FIRE;
                end
                S_FIRE: begin
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (i_wr_done) begin
                        r_ack   <= i_ack;
                        r_state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    r_gap_cnt <= '0;
                    if (!r_ack) begin
                        if (r_index == LAST_IDX) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                        end else begin
                            r_index <= r_index + 4'd1;
                            r_state <= S_GAP;
`ifdef I2C_CFG_RETRY_EN
                            r_retry <= '0;
`endif
                        end
                    end else begin
`ifdef I2C_CFG_RETRY_EN
                        // Three reissues of the same entry are allowed; the fourth NACK aborts.
                        if (r_retry != 2'd3) begin
                            r_retry <= r_retry + 2'd1;
                            r_state <= S_GAP;
                        end else begin
                            r_state <= S_ERR;
                            r_err   <= 1'b1;
                            r_busy  <= 1'b0;
                        end
`else
                        r_state <= S_ERR;
                        r_err   <= 1'b1;
                        r_busy  <= 1'b0;
`endif
                    end
                end
                S_GAP: begin
                    if (r_gap_cnt == GAP_LAST) begin
                        r_state <= S_LOAD;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 16'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_regdata = r_regdata;
    assign o_go      = r_go;
    assign o_busy    = r_busy;
    assign o_done    = r_done;
    assign o_err     = r_err;
    assign o_index   = r_index;

endmodule

// File: tb/tb_i2c_config_seq.sv
// Directed bench for i2c_config_seq: models the downstream writer (wr_done 300 cycles
// after each GO) and checks frames, GO counts, gap timing, abort and reset behaviour.
module tb_i2c_config_seq;

    localparam int         N_ENT = 10;
    localparam int         GAP   = 200;
    localparam logic [7:0] DEV   = 8'h34;

    logic        clk = 1'b0;
    logic        i_reset = 1'b0;
    logic        i_start = 1'b0;
    logic        i_wr_done = 1'b0;
    logic        i_ack = 1'b0;
    logic [26:0] o_regdata;
    logic        o_go;
    logic        o_busy;
    logic        o_done;
    logic        o_err;
    logic [3:0]  o_index;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    i2c_config_seq #(
        .N_ENTRIES  (N_ENT),
        .GAP_CYCLES (GAP),
        .DEV_ADDR   (DEV)
    ) dut (
        .i_clk     (clk),
        .i_reset   (i_reset),
        .i_start   (i_start),
        .i_wr_done (i_wr_done),
        .i_ack     (i_ack),
        .o_regdata (o_regdata),
        .o_go      (o_go),
        .o_busy    (o_busy),
        .o_done    (o_done),
        .o_err     (o_err),
        .o_index   (o_index)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [26:0] frame(input int k);
        logic [7:0] sub;
        logic [7:0] data;
        sub  = 8'(2 * k);
        data = 8'(16 + k);
        return {DEV, 1'b1, sub, 1'b1, data, 1'b1};
    endfunction

    task automatic pulse_start();
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
    endtask

    // Acts as the downstream writer. NACKs entry nack_entry up to nack_times times,
    // returns early on the GO of entry stop_idx, optionally injects start/wr_done noise.
    task automatic serve(input int nack_entry, input int nack_times, input int stop_idx,
                         input bit noise, output int gos);
        int idx;
        int nk;
        int waited;
        bit fin;
        bit ack;
        idx = 0;
        nk  = 0;
        gos = 0;
        fin = 1'b0;
        while (!fin) begin
            waited = 0;
            while (!o_go && !o_done && !o_err && waited < 2000) begin
                @(negedge clk);
                waited++;
                i_wr_done = 1'b0;
                i_start   = 1'b0;
                if (noise && waited == 50) begin
                    i_wr_done = 1'b1;
                    i_start   = 1'b1;
                end
            end
            i_wr_done = 1'b0;
            i_start   = 1'b0;
            if (o_go) begin
                gos++;
                if (gos > 1) check("gap_to_go", 32'(waited + 1), 32'(GAP + 3));
                check("frame", {5'd0, o_regdata}, {5'd0, frame(idx)});
                check("busy_at_go", {31'd0, o_busy}, 32'd1);
                if (idx == stop_idx) begin
                    fin = 1'b1;
                end else begin
                    for (int i = 0; i < 300; i++) begin
                        @(negedge clk);
                        if (o_go) gos++;
                        i_start = (noise && i == 100) ? 1'b1 : 1'b0;
                    end
                    i_start = 1'b0;
                    ack = (idx == nack_entry && nk < nack_times);
                    i_ack     = ack;
                    i_wr_done = 1'b1;
                    @(negedge clk);
                    i_wr_done = 1'b0;
                    i_ack     = 1'b0;
                    if (ack) nk++;
                    else idx++;
                end
            end else begin
                fin = 1'b1;
                if (!o_done && !o_err) check("go_wait", {31'd0, o_go}, 32'd1);
            end
        end
    endtask

    initial begin
        int gos;
        int extra;

        // Reset and reset state
        i_reset = 1'b1;
        @(negedge clk);
        i_reset = 1'b0;
        check("rst_regdata", {5'd0, o_regdata}, 32'd0);
        check("rst_go",      {31'd0, o_go},   32'd0);
        check("rst_busy",    {31'd0, o_busy}, 32'd0);
        check("rst_done",    {31'd0, o_done}, 32'd0);
        check("rst_err",     {31'd0, o_err},  32'd0);
        check("rst_index",   {28'd0, o_index}, 32'd0);

        // Full pass, all ACKed; first GO two cycles after start
        @(negedge clk);
        pulse_start();
        check("lat_go_c1", {31'd0, o_go},   32'd0);
        check("lat_busy",  {31'd0, o_busy}, 32'd1);
        @(negedge clk);
        check("lat_go_c2", {31'd0, o_go},   32'd1);
        check("entry0", {5'd0, o_regdata}, {5'd0, 27'b001101001_000000001_000100001});
        serve(-1, 0, -1, 1'b0, gos);
        check("pass_gos",   32'(gos), 32'd10);
        check("pass_done",  {31'd0, o_done}, 32'd1);
        check("pass_err",   {31'd0, o_err},  32'd0);
        check("pass_busy",  {31'd0, o_busy}, 32'd0);
        check("pass_index", {28'd0, o_index}, 32'd9);

`ifdef I2C_CFG_RETRY_EN
        // Two NACKs on entry 3 then ACK: completes with two reissues
        pulse_start();
        check("restart_done", {31'd0, o_done}, 32'd0);
        serve(3, 2, -1, 1'b0, gos);
        check("retry_gos",  32'(gos), 32'd12);
        check("retry_done", {31'd0, o_done}, 32'd1);
        check("retry_err",  {31'd0, o_err},  32'd0);

        // Four NACKs on entry 3: aborts after 7 GO pulses
        pulse_start();
        serve(3, 4, -1, 1'b0, gos);
        check("retry_abort_gos",   32'(gos), 32'd7);
        check("retry_abort_err",   {31'd0, o_err},  32'd1);
        check("retry_abort_done",  {31'd0, o_done}, 32'd0);
        check("retry_abort_index", {28'd0, o_index}, 32'd3);
        check("retry_abort_busy",  {31'd0, o_busy}, 32'd0);
`else
        // First NACK on entry 3 aborts the pass
        pulse_start();
        check("restart_done", {31'd0, o_done}, 32'd0);
        serve(3, 1, -1, 1'b0, gos);
        check("nack_gos",   32'(gos), 32'd4);
        check("nack_err",   {31'd0, o_err},  32'd1);
        check("nack_done",  {31'd0, o_done}, 32'd0);
        check("nack_index", {28'd0, o_index}, 32'd3);
        check("nack_busy",  {31'd0, o_busy}, 32'd0);
`endif

        // Reset while waiting on entry 5
        pulse_start();
        check("restart_err", {31'd0, o_err}, 32'd0);
        serve(-1, 0, 5, 1'b0, gos);
        check("midrst_gos", 32'(gos), 32'd6);
        repeat (10) @(negedge clk);
        i_reset = 1'b1;
        @(negedge clk);
        i_reset = 1'b0;
        check("midrst_regdata", {5'd0, o_regdata}, 32'd0);
        check("midrst_go",      {31'd0, o_go},   32'd0);
        check("midrst_busy",    {31'd0, o_busy}, 32'd0);
        check("midrst_done",    {31'd0, o_done}, 32'd0);
        check("midrst_err",     {31'd0, o_err},  32'd0);
        check("midrst_index",   {28'd0, o_index}, 32'd0);
        extra = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (o_go) extra++;
            i_wr_done = (i == 300) ? 1'b1 : 1'b0;
        end
        i_wr_done = 1'b0;
        check("midrst_no_go", 32'(extra), 32'd0);

        // Start pulses while busy and spurious wr_done in GAP change nothing
        pulse_start();
        @(negedge clk);
        serve(-1, 0, -1, 1'b1, gos);
        check("noise_gos",   32'(gos), 32'd10);
        check("noise_done",  {31'd0, o_done}, 32'd1);
        check("noise_err",   {31'd0, o_err},  32'd0);
        check("noise_index", {28'd0, o_index}, 32'd9);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/i2c_config_seq.md
I2C_CONFIG_SEQ -- requirements
Module: i2c_config_seq

Interface
REQ-001 SHALL have parameter N_ENTRIES, default 10, number of table entries, range 1..16.
REQ-002 SHALL have parameter GAP_CYCLES, default 200, idle CLK cycles between transactions (20 us at 10 MHz), range 1..65535.
REQ-003 SHALL have parameter DEV_ADDR, default 8'h34, 8-bit device write address placed in every frame.
REQ-004 CLK  input  1  system clock, 10 MHz nominal; one clock, all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  one-cycle pulse that begins a full table pass.
REQ-007 wr_done  input  1  one-cycle pulse from downstream I2C_write at end of the stop condition.
REQ-008 ACK  input  1  downstream aggregated ACK (ACK1|ACK2|ACK3); 1 = at least one slave NACK; valid only in the wr_done cycle.
REQ-009 regdata  output  27  frame to I2C_write: {DEV_ADDR, 1'b1, sub[7:0], 1'b1, data[7:0], 1'b1}.
REQ-010 GO  output  1  one-cycle transaction request to I2C_write.
REQ-011 busy  output  1  high from accepted start until DONE or ERR.
REQ-012 done  output  1  level; all entries written and acknowledged.
REQ-013 err  output  1  level; pass aborted on NACK.
REQ-014 index  output  4  current table entry.

Function
REQ-015 Internal read-only table SHALL hold N_ENTRIES 16-bit words {sub, data}; entry k default contents: sub = 2k, data = 8'h10 + k.
REQ-016 States SHALL be IDLE, LOAD, FIRE, WAIT, CHECK, GAP, DONE, ERR.
REQ-017 IDLE/DONE/ERR + start -> LOAD; index := 0; done, err := 0; busy := 1.
REQ-018 LOAD SHALL register regdata from table[index] in one cycle -> FIRE.
REQ-019 FIRE SHALL assert GO exactly one cycle; regdata stable from FIRE until exit from WAIT -> WAIT.
REQ-020 WAIT holds until wr_done; no timeout; wr_done outside WAIT ignored.
REQ-021 CHECK (cycle after wr_done, latched ACK): ACK = 0 and index = N_ENTRIES-1 -> DONE; ACK = 0 otherwise -> GAP with index+1; ACK = 1 -> per REQ-029/030.
REQ-022 GAP SHALL count GAP_CYCLES cycles with a 16-bit counter, then -> LOAD.
REQ-023 DONE: done = 1, busy = 0; ERR: err = 1, busy = 0; both hold until start or reset.
REQ-024 start while busy SHALL be ignored.
REQ-025 start and wr_done in same cycle: wr_done handling per state; start ignored if busy.
REQ-026 First GO SHALL occur 2 cycles after the start pulse (start cycle = 0).

Reset
REQ-027 With reset high at a rising edge: state = IDLE, regdata = 0, GO = 0, busy = 0, done = 0, err = 0, index = 0, counters = 0.
REQ-028 Reset mid-transaction SHALL abort without further GO; downstream is reset by the same signal.

Configuration
REQ-029 With I2C_CFG_RETRY_EN defined: on NACK, same entry reissued after GAP, up to 3 retries per entry (2-bit retry counter, cleared on entry advance); 4th NACK -> ERR.
REQ-030 Without I2C_CFG_RETRY_EN: first NACK -> ERR, index holds failing entry.

Verification
REQ-031 reset 1 cycle, start pulse, model ACK = 0, wr_done 300 cycles after each GO -> 10 GO pulses, regdata entry 0 = 27'b001101001_000000001_000100001, done = 1, err = 0.
REQ-032 NACK on entry 3, retry off -> err = 1, index = 3, exactly 4 GO pulses.
REQ-033 NACK on entry 3 twice then ACK, retry on -> 12 GO pulses, done = 1; three NACKs followed by a fourth -> err = 1 after 7 GO pulses.
REQ-034 Measure cycles from wr_done to next GO -> exactly GAP_CYCLES + 3.
REQ-035 Reset asserted in WAIT of entry 5 -> all outputs 0 next cycle, no GO until new start.
REQ-036 Start pulses during busy and a spurious wr_done in GAP -> no extra GO, sequence unchanged.
